uart_tx_core: RTL

Serial transmit engine that sits on the far side of the UART register block's TX handshake (data_tx / data_tx_wr / data_tx_ack, tx_busy, prescale). It accepts bytes from the register block into a one-entry holding buffer and serialises them LSB-first on txd as start / data / (parity) / stop frames. It reports per-byte acceptance, busy status and dropped writes.

---
 rtl/uart_tx_core_if.sv | 20 ++
 rtl/uart_tx_core.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core_if.sv
// TX handshake between the UART register block (master) and the serial transmit core (slave).
interface uart_tx_core_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] data_tx;
   logic                  data_tx_wr;
   logic                  data_tx_ack;
   logic                  tx_busy;
   logic                  tx_overrun;

   modport master (
      output data_tx, data_tx_wr,
      input  data_tx_ack, tx_busy, tx_overrun
   );

   modport slave (
      input  data_tx, data_tx_wr,
      output data_tx_ack, tx_busy, tx_overrun
   );
endinterface

// File: rtl/uart_tx_core.sv
// Serial transmit engine: one-entry holding buffer feeding an LSB-first start/data/stop serialiser.
// Optional macro UART_TX_PARITY_EN inserts a parity bit (sense set by PARITY_ODD) after the data bits.
//
// state  | meaning
// IDLE   | line high, waiting for a held byte with tx_enable
// START  | start bit (0) on the line
// DATA   | data bits, LSB first, one per bit period
// PARITY | parity bit (UART_TX_PARITY_EN only)
// STOP   | STOP_BITS bit periods of 1; may relaunch directly
module uart_tx_core #(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tx_enable,
   input  logic [15:0]   prescale,
   uart_tx_core_if.slave tx_if,
   output logic          txd
);
   localparam int CW = $clog2((DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t                state_q, state_nxt;
   logic [DATA_WIDTH-1:0] hold_q, shifter_q, shifter_nxt;
   logic                  hold_valid_q;
   logic [15:0]           pre_lat_q, pre_eff;
   logic [18:0]           tmr_q, bp_in, bp_lat;
   logic [CW-1:0]         cnt_q;
   logic                  bit_done, last_data, last_stop;
   logic                  launch, shift_en, cnt_clr, cnt_inc;
   logic                  txd_q, txd_nxt, busy_q, busy_nxt, ack_q, ovr_q;

   // Bit period is 8*max(prescale,1); timer reload holds BP-1 so terminal count is zero.
   assign pre_eff   = (prescale == 16'd0) ? 16'd1 : prescale;
   assign bp_in     = {pre_eff, 3'b000} - 19'd1;
   assign bp_lat    = {pre_lat_q, 3'b000} - 19'd1;
   assign bit_done  = (tmr_q == 19'd0);
   assign last_data = (cnt_q == CW'(DATA_WIDTH - 1));
   assign last_stop = (cnt_q == CW'(STOP_BITS - 1));

   assign txd               = txd_q;
   assign tx_if.tx_busy     = busy_q;
   assign tx_if.data_tx_ack = ack_q;
   assign tx_if.tx_overrun  = ovr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         shifter_q    <= '0;
         pre_lat_q    <= '0;
         tmr_q        <= '0;
         cnt_q        <= '0;
         txd_q        <= 1'b1;
         busy_q       <= 1'b0;
         ack_q        <= 1'b0;
         ovr_q        <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         shifter_q <= shifter_nxt;
         txd_q     <= txd_nxt;
         busy_q    <= busy_nxt;
         ack_q     <= launch;
         ovr_q     <= tx_if.data_tx_wr & hold_valid_q & ~launch;
         if (launch) begin
            pre_lat_q <= pre_eff;
            tmr_q     <= bp_in;
         end else if (state_q != S_IDLE) begin
            tmr_q <= bit_done ? bp_lat : tmr_q - 19'd1;
         end
         if (cnt_clr) begin
            cnt_q <= '0;
         end else if (cnt_inc) begin
            cnt_q <= cnt_q + CW'(1);
         end
         // A write landing on the launch edge refills the buffer as it empties.
         if (launch) begin
            if (tx_if.data_tx_wr) begin
               hold_q       <= tx_if.data_tx;
               hold_valid_q <= 1'b1;
            end else begin
               hold_valid_q <= 1'b0;
            end
         end else if (tx_if.data_tx_wr && !hold_valid_q) begin
            hold_q       <= tx_if.data_tx;
            hold_valid_q <= 1'b1;
         end
      end
   end

`ifdef UART_TX_PARITY_EN
   logic par_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_q <= 1'b0;
      end else if (launch) begin
         par_q <= (^hold_q) ^ PARITY_ODD;
      end
   end
`endif

   always_comb begin
      state_nxt = state_q;
      launch    = 1'b0;
      shift_en  = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hold_valid_q && tx_enable) begin
               launch    = 1'b1;
               state_nxt = S_START;
            end
         end
         S_START: begin
            if (bit_done) begin
               state_nxt = S_DATA;
               cnt_clr   = 1'b1;
            end
         end
         S_DATA: begin
            if (bit_done) begin
               shift_en = 1'b1;
               if (last_data) begin
                  cnt_clr = 1'b1;
`ifdef UART_TX_PARITY_EN
                  state_nxt = S_PARITY;
`else
                  state_nxt = S_STOP;
`endif
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_done) begin
               state_nxt = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (bit_done) begin
               if (last_stop) begin
                  cnt_clr = 1'b1;
                  if (hold_valid_q && tx_enable) begin
                     launch    = 1'b1;
                     state_nxt = S_START;
                  end else begin
                     state_nxt = S_IDLE;
                  end
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      shifter_nxt = shifter_q;
      if (launch) begin
         shifter_nxt = hold_q;
      end else if (shift_en) begin
         shifter_nxt = shifter_q >> 1;
      end
   end

   always_comb begin
      busy_nxt = (state_nxt != S_IDLE);
      txd_nxt  = 1'b1;
      case (state_nxt)
         S_START:  txd_nxt = 1'b0;
         S_DATA:   txd_nxt = shifter_nxt[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: txd_nxt = par_q;
`endif
         default:  txd_nxt = 1'b1;
      endcase
   end
endmodule
